// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// Byte lanes are big-endian: lane 0 carries bits [31:24] of the word.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] m_addr;
  logic [7:0]  m_wdata [4];
  logic        m_we;
  logic [7:0]  m_rdata [4];

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_we
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported memory with one-cycle read latency.
// Data wins contention until the fetch port has lost STARVE_LIMIT times in a row.
module mem_port_lane #(
  parameter int LANE = 0
) (
  input  logic       st_word,
  input  logic       st_rmw,
  input  logic [1:0] tgt,
  input  logic [7:0] wr_byte,
  input  logic [7:0] rd_byte,
  input  logic [7:0] mrg_byte,
  output logic [7:0] out_byte
);
  always_comb begin
    out_byte = '0;
    if (st_word)
      out_byte = wr_byte;
    else if (st_rmw)
      out_byte = (tgt == 2'(LANE)) ? mrg_byte : rd_byte;
  end
endmodule

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_b,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int NUM_LANES = 4;
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IRD, DRD, RMW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [1:0]    lane_q, lane_d;
  logic          byte_q, byte_d;
  logic [7:0]    sbyte_q, sbyte_d;

  logic          arb_ok, pick_i, pick_d, st_word, st_rmw;
  logic [31:0]   rd_word;
  logic [7:0]    wlane [NUM_LANES];
  logic          unused_bits;

  // Grants are purely combinational so a requester sees acceptance in the same cycle.
  assign arb_ok  = !rst_b && (state_q == IDLE);
  assign pick_i  = arb_ok && bus.i_req && (!bus.d_req || (starve_q == LIMIT));
  assign pick_d  = arb_ok && bus.d_req && !pick_i;
  assign st_word = pick_d && bus.d_we && !bus.d_byte;
  assign st_rmw  = !rst_b && (state_q == RMW);

  assign bus.i_gnt = pick_i;
  assign bus.d_gnt = pick_d;
  assign bus.m_we  = st_word || st_rmw;
  assign busy      = (state_q != IDLE);

  assign rd_word = {bus.m_rdata[0], bus.m_rdata[1], bus.m_rdata[2], bus.m_rdata[3]};
  assign unused_bits = ^bus.i_addr[1:0];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_port_lane #(.LANE(g)) u_lane (
      .st_word  (st_word),
      .st_rmw   (st_rmw),
      .tgt      (lane_q),
      .wr_byte  (bus.d_wdata[8*(NUM_LANES-1-g) +: 8]),
      .rd_byte  (bus.m_rdata[g]),
      .mrg_byte (sbyte_q),
      .out_byte (wlane[g])
    );
  end
  assign bus.m_wdata = wlane;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= IDLE;
      starve_q <= '0;
      waddr_q  <= '0;
      lane_q   <= '0;
      byte_q   <= 1'b0;
      sbyte_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      waddr_q  <= waddr_d;
      lane_q   <= lane_d;
      byte_q   <= byte_d;
      sbyte_q  <= sbyte_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    waddr_d      = waddr_q;
    lane_d       = lane_q;
    byte_d       = byte_q;
    sbyte_d      = sbyte_q;
    bus.m_addr   = '0;
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = '0;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          bus.m_addr = {bus.i_addr[31:2], 2'b00};
          starve_d   = '0;
          state_d    = IRD;
        end else if (pick_d) begin
          bus.m_addr = {bus.d_addr[31:2], 2'b00};
          if (bus.i_req && (starve_q != LIMIT))
            starve_d = starve_q + 1'b1;
          waddr_d = bus.d_addr[31:2];
          lane_d  = bus.d_addr[1:0];
          byte_d  = bus.d_byte;
          sbyte_d = bus.d_wdata[7:0];
          if (!bus.d_we)
            state_d = DRD;
          else if (bus.d_byte)
            state_d = RMW;
        end
      end
      IRD: begin
        if (!rst_b) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = rd_word;
        end
        state_d = IDLE;
      end
      DRD: begin
        if (!rst_b) begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = byte_q ? {24'b0, bus.m_rdata[lane_q]} : rd_word;
        end
        state_d = IDLE;
      end
      RMW: begin
        // Write back the word read last cycle with the stored byte merged in.
        bus.m_addr = {waddr_q, 2'b00};
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive data-port wins allowed while the fetch port waits.
REQ-002 Ports (name direction width meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_b  in  1  reset; synchronous, active-high.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1=store, 0=load.
- d_byte  in  1  1=byte access, 0=word access.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data; byte store uses [7:0].
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load result.
- m_addr  out  32  memory word address, bits [1:0] forced 0.
- m_wdata  out  8x4  write lanes; lane 0 = bits [31:24] (big-endian).
- m_we  out  1  memory write strobe.
- m_rdata  in  8x4  read lanes; valid the cycle after the address is presented.
- busy  out  1  FSM not in IDLE.

Function
REQ-003 States: IDLE, IRD, DRD, RMW.
REQ-004 Requests are evaluated only in IDLE. i_gnt and d_gnt are combinational from the request inputs and the state; at most one is high per cycle.
REQ-005 Arbitration when both request: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-006 starve_cnt update:
- d granted while i_req=1: increment, saturating at STARVE_LIMIT.
- i granted: clear to 0.
- otherwise: hold.
REQ-007 Fetch grant: m_addr={i_addr[31:2],00} in the grant cycle; next state IRD.
- In IRD: i_rvalid=1, i_rdata={m_rdata[0],m_rdata[1],m_rdata[2],m_rdata[3]}; next state IDLE.
REQ-008 Word load grant: same timing as fetch, using DRD.
- In DRD: d_rvalid=1, d_rdata = assembled word.
REQ-009 Byte load: DRD returns {24'b0, m_rdata[a]}, where a = latched d_addr[1:0].
REQ-010 Word store grant: m_we=1 in the grant cycle, m_wdata = d_wdata bytes [31:24],[23:16],[15:8],[7:0] on lanes 0..3; stays IDLE; no d_rvalid.
REQ-011 Byte store grant: issue a read of the aligned word; latch the address and d_wdata[7:0]; next state RMW.
- In RMW: m_we=1, m_addr = latched aligned address, m_wdata = m_rdata with lane a replaced by the latched byte; next state IDLE; no d_rvalid.
REQ-012 Throughput: loads, fetches and byte stores occupy 2 cycles; word stores occupy 1 cycle. A new grant is possible on the first IDLE cycle after completion.
REQ-013 Outside the cycles defined above: i_gnt, d_gnt, m_we, i_rvalid and d_rvalid are 0. m_addr and m_wdata are don't-care when m_we=0, except during read-address cycles.
REQ-014 Unaligned word addresses: low address bits are ignored (aligned access); no error is flagged.
REQ-015 Requests that are not granted are not latched; a requester dropping its req before grant is ignored.

Reset
REQ-016 With rst_b=1 at a clock edge:
- state = IDLE, starve_cnt = 0;
- i_gnt, d_gnt, i_rvalid, d_rvalid, m_we and busy = 0 (gnt/m_we also combinationally 0 while rst_b=1);
- i_rdata and d_rdata = 0.
REQ-017 Reset mid-operation (IRD, DRD, RMW): the in-flight read is discarded, no rvalid is produced, and a pending RMW write is never issued.

Verification
REQ-018 Scenarios:
- Fetch only: i_addr=0x10, m_rdata lanes = 11,22,33,44 -> i_gnt in cycle 0; i_rvalid in cycle 1 with i_rdata=0x11223344.
- Byte store: d_addr=0x21, d_wdata=0xAB, memory word=0x01020304 -> cycle 1: m_we=1, m_addr=0x20, lanes 01,AB,03,04.
- Byte load: d_addr=0x23, word=0x01020304 -> d_rdata=0x00000004 with d_rvalid.
- Contention: i_req and d_req held continuously, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I...
- Word store: d_addr=0x40, d_wdata=0xDEADBEEF -> single cycle, m_we=1, lanes DE,AD,BE,EF, busy stays 0.
- Reset during RMW: rst_b=1 in the RMW cycle -> m_we=0, state IDLE, no d_rvalid, memory unchanged.
